// File: rtl/alu_sub_pkg.sv
// Shared types and sizing helpers for the wide borrow-chain subtractor.
package alu_sub_pkg;

  localparam int SUB_WIDTH = 64;
  localparam int SUB_SLICE = 16;
  localparam int N_SLICES  = SUB_WIDTH / SUB_SLICE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Slice counter width; a single-slice build still needs one bit
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/borrow_chain_subtractor_if.sv
// Start/busy/done request bus of the wide subtractor. Optional abort when SUB_ABORT_EN is defined.
interface sub_if #(
  parameter int WIDTH = 64
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
`ifdef SUB_ABORT_EN
  logic             abort;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;
  logic             neg;
  logic             ovf;

`ifdef SUB_ABORT_EN
  modport master (output start, a, b, bin, abort,
                  input  busy, done, diff, bout, zero, neg, ovf);
  modport slave  (input  start, a, b, bin, abort,
                  output busy, done, diff, bout, zero, neg, ovf);
`else
  modport master (output start, a, b, bin,
                  input  busy, done, diff, bout, zero, neg, ovf);
  modport slave  (input  start, a, b, bin,
                  output busy, done, diff, bout, zero, neg, ovf);
`endif
endinterface

// File: rtl/borrow_lookahead_slice.sv
// Combinational SLICE-bit subtract x - y - bin using 4-bit group generate/propagate
// and a group-level borrow lookahead.
module borrow_lookahead_slice #(
  parameter int SLICE = 16
) (
  input  logic [SLICE-1:0] x,
  input  logic [SLICE-1:0] y,
  input  logic             bin,
  output logic [SLICE-1:0] d,
  output logic             bout
);
  localparam int NG = SLICE / 4;

  logic [SLICE-1:0] g, p, bb;
  logic [NG-1:0]    gg, gp;
  logic [NG:0]      gb;

  always_comb begin
    g  = ~x & y;
    p  = ~(x ^ y);
    gg = '0;
    gp = '0;
    for (int j = 0; j < NG; j++) begin
      gg[j] = g[4*j+3]
            | (p[4*j+3] & g[4*j+2])
            | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      gp[j] = &p[4*j +: 4];
    end
    gb    = '0;
    gb[0] = bin;
    for (int j = 0; j < NG; j++) begin
      gb[j+1] = gg[j] | (gp[j] & gb[j]);
    end
    // Per-bit borrows inside each group are expanded from that group's borrow-in
    bb = '0;
    for (int j = 0; j < NG; j++) begin
      bb[4*j]   = gb[j];
      bb[4*j+1] = g[4*j] | (p[4*j] & gb[j]);
      bb[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j])
                | (p[4*j+1] & p[4*j] & gb[j]);
      bb[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1])
                | (p[4*j+2] & p[4*j+1] & g[4*j])
                | (p[4*j+2] & p[4*j+1] & p[4*j] & gb[j]);
    end
    d    = x ^ y ^ bb;
    bout = gb[NG];
  end

endmodule

// File: rtl/borrow_chain_subtractor.sv
// Multi-cycle wide subtractor: one SLICE-bit lookahead slice per clock, LSB first.
// Define SUB_ABORT_EN to add an abort input and a shadow result register.
module borrow_chain_subtractor
  import alu_sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH,
  parameter int SLICE = SUB_SLICE
) (
  input  logic  clk,
  input  logic  rst,
  sub_if.slave  bus
);
  localparam int N  = WIDTH / SLICE;
  localparam int CW = cnt_width(N);

  state_t                  state_q, state_d;
  logic [N-1:0][SLICE-1:0] a_q, b_q, res_q, diff_fin;
  logic [CW-1:0]           cnt_q;
  logic                    brw_q;
  logic                    bout_q, zero_q, neg_q, ovf_q;
  logic [SLICE-1:0]        slice_d;
  logic                    slice_bout;
  logic                    accept, last, abort_req, run_step;
  logic                    busy_c, done_c;

`ifdef SUB_ABORT_EN
  logic [N-1:0][SLICE-1:0] diff_q;
  assign abort_req = bus.abort;
  assign bus.diff  = diff_q;
`else
  assign abort_req = 1'b0;
  assign bus.diff  = res_q;
`endif

  assign accept   = bus.start & ((state_q == IDLE) | (state_q == DONE));
  assign last     = (cnt_q == CW'(N - 1));
  assign run_step = (state_q == RUN) & ~abort_req;

  borrow_lookahead_slice #(.SLICE(SLICE)) u_slice (
    .x    (a_q[cnt_q]),
    .y    (b_q[cnt_q]),
    .bin  (brw_q),
    .d    (slice_d),
    .bout (slice_bout)
  );

  always_comb begin
    diff_fin        = res_q;
    diff_fin[cnt_q] = slice_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (abort_req) state_d = IDLE;
               else if (last) state_d = DONE;
      DONE:    state_d = bus.start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_c = 1'b0;
    done_c = 1'b0;
    case (state_q)
      RUN:     busy_c = 1'b1;
      DONE:    done_c = 1'b1;
      default: ;
    endcase
  end

  assign bus.busy = busy_c;
  assign bus.done = done_c;
  assign bus.bout = bout_q;
  assign bus.zero = zero_q;
  assign bus.neg  = neg_q;
  assign bus.ovf  = ovf_q;

  // Flags are computed from the fully assembled result on the last slice edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      cnt_q  <= '0;
      brw_q  <= 1'b0;
      bout_q <= 1'b0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      ovf_q  <= 1'b0;
`ifdef SUB_ABORT_EN
      diff_q <= '0;
`endif
    end else if (accept) begin
      a_q   <= bus.a;
      b_q   <= bus.b;
      brw_q <= bus.bin;
      cnt_q <= '0;
    end else if (run_step) begin
      res_q <= diff_fin;
      brw_q <= slice_bout;
      cnt_q <= cnt_q + CW'(1);
      if (last) begin
        bout_q <= slice_bout;
        zero_q <= ~|diff_fin;
        neg_q  <= diff_fin[N-1][SLICE-1];
        ovf_q  <= (a_q[N-1][SLICE-1] != b_q[N-1][SLICE-1]) &
                  (diff_fin[N-1][SLICE-1] != a_q[N-1][SLICE-1]);
`ifdef SUB_ABORT_EN
        diff_q <= diff_fin;
`endif
      end
    end
  end

endmodule
